// File: rtl/inst_fetch_queue.sv
// Fetch-to-dispatch decoupling FIFO.
// One push per cycle, up to two in-order pops per cycle, single-cycle flush.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       enq_valid_in,
  output logic                       enq_ready_out,
  input  logic [XLEN-1:0]            enq_pc_in,
  input  logic [XLEN-1:0]            enq_inst_in,
  output logic                       deq0_valid_out,
  output logic [XLEN-1:0]            deq0_pc_out,
  output logic [XLEN-1:0]            deq0_inst_out,
  output logic                       deq1_valid_out,
  output logic [XLEN-1:0]            deq1_pc_out,
  output logic [XLEN-1:0]            deq1_inst_out,
  input  logic [1:0]                 deq_take_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [1:0]    req;
  logic [1:0]    eff_take;
  logic          push;

  assign enq_ready_out = (count < FULL);
  assign push = enq_valid_in & enq_ready_out & ~flush_in;
  assign head_p1 = head + 1'b1;
  assign count_out = count;

  // Clamp the pop request to what is actually held; 3 is treated as 2.
  always_comb begin
    req = (deq_take_in == 2'd3) ? 2'd2 : deq_take_in;
    eff_take = req;
    if (count < CW'(req))
      eff_take = count[1:0];
  end

  assign count_next = count + CW'(push) - CW'(eff_take);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case (1'b1)
        flush_in: begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
        default: begin
          head  <= head + AW'(eff_take);
          tail  <= tail + AW'(push);
          count <= count_next;
        end
      endcase
    end
  end

  // Storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[tail]   <= enq_pc_in;
      inst_mem[tail] <= enq_inst_in;
    end
  end

  assign deq0_valid_out = (count >= CW'(1));
  assign deq1_valid_out = (count >= CW'(2));

  always_comb begin
    deq0_pc_out   = '0;
    deq0_inst_out = NOP;
    deq1_pc_out   = '0;
    deq1_inst_out = NOP;
    if (deq0_valid_out) begin
      deq0_pc_out   = pc_mem[head];
      deq0_inst_out = inst_mem[head];
    end
    if (deq1_valid_out) begin
      deq1_pc_out   = pc_mem[head_p1];
      deq1_inst_out = inst_mem[head_p1];
    end
  end

endmodule
